// File: rtl/uart_rx_frame_sampler.sv
// UART receive framer: oversamples the synchronised RX line, majority-votes each bit and
// delivers LSB-first frames through a single-entry valid/ready buffer with error pulses.
module uart_rx_frame_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_sync,
    input  logic                 sample_tick,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_payload,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [TW-1:0] TICK_S0   = TW'(M - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(M);
    localparam logic [TW-1:0] TICK_DEC  = TW'(M + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_next;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [1:0]           samp;
    logic                 par_bad;
    logic                 vote, decide, wrap;
    logic                 frame_done, take, load, buf_free;

    // The live line is the third vote, so the decision lands on the M+1 tick itself.
    assign vote   = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
    assign decide = sample_tick && (tick_cnt == TICK_DEC);
    assign wrap   = sample_tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (sample_tick)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (sample_tick && !rx_sync) state_next = START;
            START: begin
                if (decide && vote)
                    state_next = IDLE;
                else if (wrap)
                    state_next = DATA;
            end
            DATA:  if (wrap && bit_cnt == BIT_LAST) state_next = (PARITY != 0) ? PAR : STOP;
            PAR:   if (wrap) state_next = STOP;
            STOP:  if (decide) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        frame_done = (state == STOP) && decide;
        take       = out_valid && out_ready;
        buf_free   = !out_valid || take;
        load       = frame_done && vote && !par_bad && buf_free;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            samp      <= '0;
            par_bad   <= 1'b0;
        end else if (sample_tick) begin
            if (state == IDLE) begin
                tick_cnt <= rx_sync ? '0 : TW'(1);
                bit_cnt  <= '0;
                par_bad  <= 1'b0;
            end else begin
                if (state_next == IDLE || wrap)
                    tick_cnt <= '0;
                else
                    tick_cnt <= tick_cnt + TW'(1);
                if (tick_cnt == TICK_S0)
                    samp[0] <= rx_sync;
                if (tick_cnt == TICK_S1)
                    samp[1] <= rx_sync;
                if (state == DATA && decide)
                    shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                if (state == DATA && wrap)
                    bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
                if (state == PAR && decide)
                    par_bad <= ((^shift_reg) ^ vote) != (PARITY == 2);
            end
        end
    end

    // Errors are mutually exclusive by construction, giving at most one pulse per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= frame_done && !vote;
            err_parity  <= frame_done && vote && par_bad;
            err_overrun <= frame_done && vote && !par_bad && !buf_free;
            if (load) begin
                out_valid   <= 1'b1;
                out_payload <= shift_reg;
            end else if (take) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
